// File: rtl/mapper_cfg_seq.sv
// AXI4-Lite master that programs and supervises the BPSK/QPSK mapper CSR slave.
// A valid/ready request runs four transactions in a fixed order: a SW_RESET CTRL
// write, an ENABLE CTRL write, a STATUS W1C clear and a STATUS read-back. While
// idle and configured, the block polls STATUS, latches RUNNING/OVERFLOW and
// clears OVERFLOW.
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready       : request handshake; cfg_mode/cfg_bypass captured at accept
//   cfg_done, cfg_err         : completion pulse, sticky error
//   configured_o, running_o, overflow_o : supervision status
//   m_axi_*                   : AXI4-Lite master (AW/W/B/AR/R channels)
module mapper_cfg_seq #(
  parameter logic [7:0]  CTRL_ADDR   = 8'h00,
  parameter logic [7:0]  STATUS_ADDR = 8'h04,
  parameter int unsigned POLL_DIV    = 1024,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_mode,
  input  logic        cfg_bypass,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        configured_o,
  output logic        running_o,
  output logic        overflow_o,
  output logic [7:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [7:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_RST, WR_EN, WR_CLR, RD_STAT, POLL_RD, POLL_CLR, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic          bypass_q, bypass_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic        cfg_ready_d, cfg_done_d, cfg_err_d;
  logic        configured_d, running_d, overflow_d;
  logic [7:0]  awaddr_d, araddr_d;
  logic [31:0] wdata_d;
  logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

  logic        wr_issue, rd_issue, err_go;
  logic [7:0]  iss_addr;
  logic [31:0] iss_data;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, tmo, accept;

  // Only RUNNING and OVERFLOW are used from the STATUS read data.
  logic unused_rdata;
  assign unused_rdata = ^{m_axi_rdata[31:3], m_axi_rdata[1]};

  assign m_axi_wstrb = 4'hF;

  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid  & m_axi_wready;
  assign b_hs   = m_axi_bvalid  & m_axi_bready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_hs   = m_axi_rvalid  & m_axi_rready;
  assign tmo    = (tcnt_q == TW'(TIMEOUT - 1));
  assign accept = cfg_valid & cfg_ready & (state_q == IDLE);

  // CTRL word: AMC_OVERRIDE always set, MODE at [6:4], BYPASS at [1], then SW_RESET or ENABLE.
  function automatic logic [31:0] ctrl_word(input logic [2:0] mode, input logic bypass,
                                            input logic sw_reset);
    return 32'h100 | (32'(mode) << 4) | (32'(bypass) << 1) | (sw_reset ? 32'h4 : 32'h1);
  endfunction

  // State and registered outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= IDLE;
      mode_q        <= '0;
      bypass_q      <= 1'b0;
      pcnt_q        <= '0;
      tcnt_q        <= '0;
      cfg_ready     <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      configured_o  <= 1'b0;
      running_o     <= 1'b0;
      overflow_o    <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      bypass_q      <= bypass_d;
      pcnt_q        <= pcnt_d;
      tcnt_q        <= tcnt_d;
      cfg_ready     <= cfg_ready_d;
      cfg_done      <= cfg_done_d;
      cfg_err       <= cfg_err_d;
      configured_o  <= configured_d;
      running_o     <= running_d;
      overflow_o    <= overflow_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    bypass_d     = bypass_q;
    pcnt_d       = pcnt_q;
    tcnt_d       = tcnt_q + TW'(1);
    cfg_done_d   = 1'b0;
    cfg_err_d    = cfg_err;
    configured_d = configured_o;
    running_d    = running_o;
    overflow_d   = overflow_o;
    awaddr_d     = m_axi_awaddr;
    awvalid_d    = m_axi_awvalid & ~aw_hs;
    wdata_d      = m_axi_wdata;
    wvalid_d     = m_axi_wvalid & ~w_hs;
    bready_d     = m_axi_bready;
    araddr_d     = m_axi_araddr;
    arvalid_d    = m_axi_arvalid & ~ar_hs;
    rready_d     = m_axi_rready;
    wr_issue     = 1'b0;
    rd_issue     = 1'b0;
    err_go       = 1'b0;
    iss_addr     = CTRL_ADDR;
    iss_data     = '0;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        // A request beats a simultaneous poll expiry.
        if (accept) begin
          mode_d     = cfg_mode;
          bypass_d   = cfg_bypass;
          cfg_err_d  = 1'b0;
          overflow_d = 1'b0;
          pcnt_d     = '0;
          wr_issue   = 1'b1;
          iss_addr   = CTRL_ADDR;
          iss_data   = ctrl_word(cfg_mode, cfg_bypass, 1'b1);
          state_d    = WR_RST;
        end else if (configured_o) begin
          if (pcnt_q == PW'(POLL_DIV - 1)) begin
            pcnt_d   = '0;
            rd_issue = 1'b1;
            state_d  = POLL_RD;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
      end

      WR_RST, WR_EN, WR_CLR, POLL_CLR: begin
        if (b_hs) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            err_go = 1'b1;
          end else begin
            case (state_q)
              WR_RST: begin
                wr_issue = 1'b1;
                iss_addr = CTRL_ADDR;
                iss_data = ctrl_word(mode_q, bypass_q, 1'b0);
                state_d  = WR_EN;
              end
              WR_EN: begin
                wr_issue = 1'b1;
                iss_addr = STATUS_ADDR;
                iss_data = 32'h5;
                state_d  = WR_CLR;
              end
              WR_CLR: begin
                rd_issue = 1'b1;
                state_d  = RD_STAT;
              end
              default: state_d = IDLE;
            endcase
          end
        end else if (tmo) begin
          err_go = 1'b1;
        end
      end

      RD_STAT, POLL_RD: begin
        if (r_hs) begin
          rready_d = 1'b0;
          if (m_axi_rresp != 2'b00) begin
            err_go = 1'b1;
          end else begin
            running_d = m_axi_rdata[0];
            if (m_axi_rdata[2]) overflow_d = 1'b1;
            if (state_q == RD_STAT) begin
              cfg_done_d   = 1'b1;
              configured_d = 1'b1;
              state_d      = IDLE;
            end else if (m_axi_rdata[2]) begin
              // Clear only OVERFLOW; RUNNING is left untouched.
              wr_issue = 1'b1;
              iss_addr = STATUS_ADDR;
              iss_data = 32'h4;
              state_d  = POLL_CLR;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (tmo) begin
          err_go = 1'b1;
        end
      end

      // One drain cycle with bready/rready high swallows a late response.
      ERR: begin
        bready_d = 1'b0;
        rready_d = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (wr_issue) begin
      awaddr_d  = iss_addr;
      wdata_d   = iss_data;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      bready_d  = 1'b1;
      tcnt_d    = '0;
    end
    if (rd_issue) begin
      araddr_d  = STATUS_ADDR;
      arvalid_d = 1'b1;
      rready_d  = 1'b1;
      tcnt_d    = '0;
    end
    if (err_go) begin
      state_d      = ERR;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      arvalid_d    = 1'b0;
      bready_d     = 1'b1;
      rready_d     = 1'b1;
      cfg_err_d    = 1'b1;
      configured_d = 1'b0;
    end

    cfg_ready_d = (state_d == IDLE);
  end

endmodule
